// File: rtl/bus_destination_bank.sv
// Receiving end of the internal data bus: a bank of destination registers with load flags, a load counter and error tracking.
// Optional macro DEST_READBACK_EN adds a combinational readback port (readSelect -> readData).
module bus_destination_bank #(
  parameter int DEST_COUNT = 4,
  parameter int WIDTH      = 8,
  parameter int INDEX_SIZE = (DEST_COUNT > 1) ? $clog2(DEST_COUNT) : 1
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic [WIDTH-1:0]            busValue,
  input  logic                        loadValid,
  input  logic [DEST_COUNT-1:0]       loadSelect,
  input  logic                        clearFlags,
  output logic [WIDTH*DEST_COUNT-1:0] destOutputs,
  output logic [DEST_COUNT-1:0]       loadedFlags,
  output logic [7:0]                  loadCount,
  output logic [INDEX_SIZE-1:0]       lastIndex,
  output logic                        multiLoad,
  output logic                        errorFlag
`ifdef DEST_READBACK_EN
  ,
  input  logic [DEST_COUNT-1:0]       readSelect,
  output logic [WIDTH-1:0]            readData
`endif
);

  logic [DEST_COUNT-1:0][WIDTH-1:0] dest_q;
  logic                             accept;
  logic                             err_strobe;
  logic [INDEX_SIZE-1:0]            low_idx;
  logic                             is_broadcast;
  logic [DEST_COUNT-1:0]            flags_base;
  logic [7:0]                       count_base;
  logic                             err_base;

  assign accept       = loadValid && (loadSelect != '0);
  assign err_strobe   = loadValid && (loadSelect == '0);
  // Clearing x & (x-1) drops the lowest set bit; anything left means two or more targets.
  assign is_broadcast = (loadSelect & (loadSelect - 1'b1)) != '0;

  // A same-cycle clear acts first, so the load/error event is layered on zeroed state.
  assign flags_base = clearFlags ? '0    : loadedFlags;
  assign count_base = clearFlags ? 8'd0  : loadCount;
  assign err_base   = clearFlags ? 1'b0  : errorFlag;

  // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    low_idx = '0;
    for (int i = DEST_COUNT - 1; i >= 0; i--) begin
      if (loadSelect[i]) low_idx = INDEX_SIZE'(i);
    end
  end

  // NOTE: the register bank is reset with everything else because its outputs must read zero immediately after reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dest_q      <= '0;
      loadedFlags <= '0;
      loadCount   <= 8'd0;
      lastIndex   <= '0;
      multiLoad   <= 1'b0;
      errorFlag   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      errorFlag <= err_base | err_strobe;
      if (accept) begin
        for (int i = 0; i < DEST_COUNT; i++) begin
          if (loadSelect[i]) dest_q[i] <= busValue;
        end
        loadedFlags <= flags_base | loadSelect;
        loadCount   <= (count_base == 8'hFF) ? 8'hFF : count_base + 8'd1;
        lastIndex   <= low_idx;
        multiLoad   <= is_broadcast;
      end else begin
        loadedFlags <= flags_base;
        loadCount   <= count_base;
      end
    end
  end

  assign destOutputs = dest_q;

`ifdef DEST_READBACK_EN
  // Lowest selected register wins; no selection falls back to register 0.
  always_comb begin
    readData = dest_q[0];
    for (int i = DEST_COUNT - 1; i >= 0; i--) begin
      if (readSelect[i]) readData = dest_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_bus_destination_bank.sv
// Randomized and directed bench for bus_destination_bank against a behavioural model of the bank.
module tb_bus_destination_bank;

  localparam int DC = 4;
  localparam int W  = 8;
  localparam int IS = 2;

  logic              clk = 1'b0;
  logic              nrst;
  logic [W-1:0]      busValue;
  logic              loadValid;
  logic [DC-1:0]     loadSelect;
  logic              clearFlags;
  logic [W*DC-1:0]   destOutputs;
  logic [DC-1:0]     loadedFlags;
  logic [7:0]        loadCount;
  logic [IS-1:0]     lastIndex;
  logic              multiLoad;
  logic              errorFlag;
`ifdef DEST_READBACK_EN
  logic [DC-1:0]     readSelect;
  logic [W-1:0]      readData;
`endif

  bus_destination_bank #(.DEST_COUNT(DC), .WIDTH(W)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .busValue   (busValue),
    .loadValid  (loadValid),
    .loadSelect (loadSelect),
    .clearFlags (clearFlags),
    .destOutputs(destOutputs),
    .loadedFlags(loadedFlags),
    .loadCount  (loadCount),
    .lastIndex  (lastIndex),
    .multiLoad  (multiLoad),
    .errorFlag  (errorFlag)
`ifdef DEST_READBACK_EN
    ,
    .readSelect (readSelect),
    .readData   (readData)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0]  m_regs [DC];
  logic [DC-1:0] m_flags;
  int            m_count;
  int            m_last;
  bit            m_multi;
  bit            m_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DC; i++) m_regs[i] = '0;
    m_flags = '0;
    m_count = 0;
    m_last  = 0;
    m_multi = 0;
    m_err   = 0;
  endtask

  task automatic model_apply(input bit valid, input logic [DC-1:0] sel, input logic [W-1:0] bus, input bit clr);
    if (clr) begin
      m_flags = '0;
      m_count = 0;
      m_err   = 0;
    end
    if (valid && sel == '0) m_err = 1;
    if (valid && sel != '0) begin
      for (int i = 0; i < DC; i++) if (sel[i]) m_regs[i] = bus;
      m_flags = m_flags | sel;
      if (m_count < 255) m_count = m_count + 1;
      m_last = -1;
      for (int i = 0; i < DC; i++) if (sel[i] && m_last < 0) m_last = i;
      m_multi = $countones(sel) > 1;
    end
  endtask

  function automatic logic [W*DC-1:0] model_dest();
    logic [W*DC-1:0] v;
    for (int i = 0; i < DC; i++) v[i*W +: W] = m_regs[i];
    return v;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".dest"},  destOutputs, model_dest());
    check({tag, ".flags"}, loadedFlags, m_flags);
    check({tag, ".count"}, loadCount,   m_count);
    check({tag, ".last"},  lastIndex,   m_last);
    check({tag, ".multi"}, multiLoad,   m_multi);
    check({tag, ".err"},   errorFlag,   m_err);
  endtask

  // Drives one cycle of stimulus, lets the edge happen, then compares just after it.
  task automatic step(input string tag, input bit valid, input logic [DC-1:0] sel,
                      input logic [W-1:0] bus, input bit clr);
    loadValid  = valid;
    loadSelect = sel;
    busValue   = bus;
    clearFlags = clr;
    @(posedge clk);
    model_apply(valid, sel, bus, clr);
    #1;
    loadValid  = 1'b0;
    loadSelect = '0;
    busValue   = '0;
    clearFlags = 1'b0;
    check_all(tag);
  endtask

  initial begin
    nrst       = 1'b0;
    loadValid  = 1'b0;
    loadSelect = '0;
    busValue   = '0;
    clearFlags = 1'b0;
`ifdef DEST_READBACK_EN
    readSelect = '0;
`endif
    model_reset();
    #12;
    check_all("por");
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // Single load and broadcast
    step("single", 1'b1, 4'b0100, 8'hA5, 1'b0);
    step("bcast",  1'b1, 4'b1011, 8'h3C, 1'b0);
    // Error strobe, then gated strobe
    step("errstb", 1'b1, 4'b0000, 8'h77, 1'b0);
    step("gated",  1'b0, 4'b1111, 8'hFF, 1'b0);
    step("clr",    1'b0, 4'b0000, 8'h00, 1'b1);
    step("clrerr", 1'b1, 4'b0000, 8'h11, 1'b1);

    // Asynchronous reset in mid-cycle after loads
    step("preRst", 1'b1, 4'b1111, 8'h5E, 1'b0);
    #3;
    nrst = 1'b0;
    #1;
    model_reset();
    check_all("rstImm");
    loadValid  = 1'b1;
    loadSelect = 4'b1111;
    busValue   = 8'hEE;
    @(posedge clk);
    #1;
    check_all("rstHold");
    loadValid  = 1'b0;
    loadSelect = '0;
    busValue   = '0;
    #2;
    nrst = 1'b1;
    step("postRst", 1'b0, 4'b0000, 8'h00, 1'b0);

    // Saturation of the counter
    for (int i = 0; i < 300; i++) begin
      step("sat", 1'b1, 4'($urandom_range(1, 15)), 8'($urandom), 1'b0);
    end
    check("satCount", loadCount, 8'd255);
    step("satErr",  1'b1, 4'b0000, 8'h00, 1'b0);
    step("clrLoad", 1'b1, 4'b0001, 8'h42, 1'b1);
    check("clrLoadCount", loadCount, 8'd1);
    check("clrLoadFlags", loadedFlags, 4'b0001);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd", $urandom_range(0, 3) != 0,
           ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom_range(0, 15)),
           8'($urandom), $urandom_range(0, 7) == 0);
    end

`ifdef DEST_READBACK_EN
    step("rb1", 1'b1, 4'b0010, 8'h5A, 1'b0);
    step("rb3", 1'b1, 4'b1000, 8'hC3, 1'b0);
    readSelect = 4'b0010;
    #1;
    check("rdSel1", readData, m_regs[1]);
    check("rdSel1Const", readData, 8'h5A);
    readSelect = 4'b1010;
    #1;
    check("rdMulti", readData, 8'h5A);
    readSelect = 4'b1000;
    #1;
    check("rdSel3", readData, 8'hC3);
    readSelect = 4'b0000;
    #1;
    check("rdNone", readData, m_regs[0]);
    step("rdNoState", 1'b0, 4'b0000, 8'h00, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_destination_bank.md
Name: bus_destination_bank

Overview:
- Receiving end of the internal data bus: a bank of DEST_COUNT destination registers that capture the bus value when told to.
- The bus source mux drives busValue. The control unit drives loadSelect and loadValid.
- Provides per-destination loaded flags, a saturating load-event counter, the last-loaded index, and a sticky error for strobes with no destination.
- Sits between the internal bus and the datapath registers (A, X, Y, ALU inputs, ...).

Parameters:
- DEST_COUNT, 4, number of destination registers (>=1).
- WIDTH, 8, bus and register width in bits.
- INDEX_SIZE, (DEST_COUNT>1)?$clog2(DEST_COUNT):1, width of encoded index outputs.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- nrst  input  1  asynchronous active-low reset
- busValue  input  WIDTH  current internal bus value
- loadValid  input  1  load strobe for this cycle
- loadSelect  input  DEST_COUNT  destination enables; more than one bit set = broadcast
- clearFlags  input  1  synchronous clear of loadedFlags, errorFlag, loadCount
- destOutputs  output  WIDTH*DEST_COUNT  packed registers; register i at bits [WIDTH*(i+1)-1:WIDTH*i]
- loadedFlags  output  DEST_COUNT  sticky: register i written since last clear/reset
- loadCount  output  8  saturating count of accepted load events
- lastIndex  output  INDEX_SIZE  lowest index written by the most recent accepted load
- multiLoad  output  1  registered: the most recent accepted load was a broadcast
- errorFlag  output  1  sticky: loadValid seen with loadSelect == 0

Behaviour:
- Reset (nrst low, asynchronous, any time including mid-load):
  - All registers, loadedFlags, loadCount, lastIndex, multiLoad and errorFlag go to 0 immediately.
  - They stay 0 until the first clk edge with nrst high.
- Accepted load = loadValid && (loadSelect != 0), sampled at the rising clk edge.
- On an accepted load, every register i with loadSelect[i]=1 takes busValue. Unselected registers hold their value.
- Latency: one cycle. The new value appears on destOutputs after the capturing edge. There is no combinational path from busValue to destOutputs.
- loadValid=0: no register, flag or counter change, whatever loadSelect is.
- loadedFlags[i] is set by an accepted load that includes i.
- loadCount increments by exactly 1 per accepted load, broadcast included, and saturates at 255 (no wrap).
- lastIndex is updated only on an accepted load. It takes the lowest set index in loadSelect, using a priority encoder from the LSB.
- multiLoad is updated only on an accepted load: 1 if popcount(loadSelect) > 1, else 0.
- Error strobe: loadValid=1 with loadSelect=0 sets errorFlag. No other state changes; loadCount is not incremented.
- clearFlags alone: loadedFlags, errorFlag and loadCount go to 0 next edge. Register contents, lastIndex and multiLoad are kept.
- clearFlags together with an accepted load in the same cycle:
  - Flags and count clear first, then the load applies.
  - Result: loadedFlags = loadSelect, loadCount = 1, and the registers are written.
- clearFlags together with an error strobe: errorFlag = 1 (the event wins).

Optional Feature:
- Macro: DEST_READBACK_EN.
- Defined:
  - Adds input readSelect (DEST_COUNT, one-hot) and output readData (WIDTH).
  - readData is combinationally the register selected by readSelect.
  - If readSelect is zero or has more than one bit set, readData shows the lowest-index set register, or register 0 when no bit is set.
  - Reads never change state.
- Undefined: the ports are absent and there is no readback logic. All other behaviour is identical.

Test Plan:
- Reset check: assert nrst=0 mid-cycle after loads -> all outputs 0 immediately; release, no strobe -> outputs stay 0.
- Single load: busValue=8'hA5, loadSelect=4'b0100, loadValid=1 for one cycle:
  - Next cycle: register 2 = A5, others 0, loadedFlags = 0100, loadCount = 1, lastIndex = 2, multiLoad = 0.
- Broadcast: busValue=8'h3C, loadSelect=4'b1011:
  - Registers 0, 1, 3 = 3C; register 2 unchanged; loadCount += 1; lastIndex = 0; multiLoad = 1.
- Error strobe and loadValid gating:
  - loadValid=1, loadSelect=0 -> errorFlag=1, count and registers unchanged.
  - loadValid=0, loadSelect=4'b1111, busValue=FF -> nothing changes.
- Saturation and clear:
  - 300 accepted loads -> loadCount = 255.
  - clearFlags together with loadSelect=0001 -> loadCount = 1, loadedFlags = 0001, errorFlag = 0.
- With DEST_READBACK_EN, after register 1 = 5A and register 3 = C3:
  - readSelect=0010 -> 5A.
  - readSelect=1010 -> 5A (lowest index wins).
  - readSelect=0000 -> register 0 contents.
